sr_trace_buffer: RTL and testbench



---
 rtl/sr_trace_buffer_pkg.sv | 32 +++
 rtl/sr_trace_ram.sv | 37 +++
 rtl/sr_trace_buffer.sv | 150 +++++++++++++++
 tb/tb_sr_trace_buffer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_trace_buffer_pkg.sv
// Shared types and helpers for the schoolRISCV instruction-trace recorder.
// Holds the capture FSM encoding and the packed trace-entry width helper.
package sr_trace_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FROZEN  = 2'd2
  } state_e;

  // Packed entry layout, MSB to LSB: {pc, instr, regVal, cycle}.
  function automatic int entryWidth(input int pcW, input int dataW, input int cycleW);
    return pcW + 2 * dataW + cycleW;
  endfunction

  function automatic int cycleLsb();
    return 0;
  endfunction

  function automatic int valLsb(input int cycleW);
    return cycleW;
  endfunction

  function automatic int instrLsb(input int dataW, input int cycleW);
    return cycleW + dataW;
  endfunction

  function automatic int pcLsb(input int dataW, input int cycleW);
    return cycleW + 2 * dataW;
  endfunction

endpackage

// File: rtl/sr_trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered read.
// The array itself is never reset; only the read register clears on rst.
module sr_trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 112,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdData_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wrAddr] <= wrData;
    end
  end

  // Read-during-write to the same address returns the previous contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdData_q <= '0;
    end else begin
      rdData_q <= mem_q[rdAddr];
    end
  end

  assign rdData = rdData_q;

endmodule

// File: rtl/sr_trace_buffer.sv
// Instruction-trace recorder: one entry per retired instruction into a
// circular buffer, with wrap / freeze-when-full modes and a cycle watchdog.
module sr_trace_buffer
  import sr_trace_buffer_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int PC_W    = 32,
  parameter int DATA_W  = 32,
  parameter int CYCLE_W = 16,
  parameter int TIMEOUT = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     clear,
  input  logic                     stopFull,
  input  logic                     valid,
  input  logic [PC_W-1:0]          pc,
  input  logic [DATA_W-1:0]        instr,
  input  logic [DATA_W-1:0]        regVal,
  input  logic [$clog2(DEPTH)-1:0] rdIdx,
  output logic [PC_W-1:0]          rdPc,
  output logic [DATA_W-1:0]        rdInstr,
  output logic [DATA_W-1:0]        rdVal,
  output logic [CYCLE_W-1:0]       rdCycle,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wrapped,
  output logic                     capturing,
  output logic                     timeout,
  output logic                     halt
);

  localparam int AW        = $clog2(DEPTH);
  localparam int EW        = entryWidth(PC_W, DATA_W, CYCLE_W);
  localparam int CYC_LSB   = cycleLsb();
  localparam int VAL_LSB   = valLsb(CYCLE_W);
  localparam int INSTR_LSB = instrLsb(DATA_W, CYCLE_W);
  localparam int PC_LSB    = pcLsb(DATA_W, CYCLE_W);

  localparam logic [AW:0]        DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [CYCLE_W-1:0] CYC_MAX = '1;
  localparam logic [31:0]        TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_e             state_q;
  logic [CYCLE_W-1:0] cycle_q;
  logic [AW-1:0]      wrPtr_q;
  logic [AW:0]        count_q;
  logic               wrapped_q;
  logic               stopFull_q;
  logic               timeout_q;

  logic               we;
  logic               full;
  logic               fire;
  logic               freeze;
  logic [AW:0]        count_d;
  logic [AW-1:0]      oldest;
  logic [AW-1:0]      rdAddr;
  logic [EW-1:0]      wrData;
  logic [EW-1:0]      rdData;

  always_comb begin
    we      = (state_q == CAPTURE) && valid && !clear;
    full    = (count_q == DEPTH_C);
    count_d = (we && !full) ? count_q + 1'b1 : count_q;
    fire    = (TIMEOUT != 0) && (state_q == CAPTURE) && (32'(cycle_q) == TO_LAST);
    // Freeze decision looks at the post-write count so the DEPTH-th capture stops it.
    freeze  = fire || ((state_q == CAPTURE) && stopFull_q && (count_d == DEPTH_C));
    oldest  = wrapped_q ? wrPtr_q : '0;
    rdAddr  = oldest + rdIdx;
    wrData  = {pc, instr, regVal, cycle_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cycle_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      stopFull_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (clear) begin
      state_q   <= IDLE;
      count_q   <= '0;
      wrapped_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_q    <= CAPTURE;
            cycle_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            wrapped_q  <= 1'b0;
            timeout_q  <= 1'b0;
            stopFull_q <= stopFull;
          end
        end
        CAPTURE: begin
          if (cycle_q != CYC_MAX) begin
            cycle_q <= cycle_q + 1'b1;
          end
          if (we) begin
            wrPtr_q <= wrPtr_q + 1'b1;
            count_q <= count_d;
            if (full) begin
              wrapped_q <= 1'b1;
            end
          end
          if (fire) begin
            timeout_q <= 1'b1;
          end
          if (freeze) begin
            state_q <= FROZEN;
          end
        end
        FROZEN: begin
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sr_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) uRam (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .wrAddr (wrPtr_q),
    .wrData (wrData),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );

  assign rdPc      = rdData[PC_LSB +: PC_W];
  assign rdInstr   = rdData[INSTR_LSB +: DATA_W];
  assign rdVal     = rdData[VAL_LSB +: DATA_W];
  assign rdCycle   = rdData[CYC_LSB +: CYCLE_W];
  assign count     = count_q;
  assign wrapped   = wrapped_q;
  assign capturing = (state_q == CAPTURE);
  assign timeout   = timeout_q;
  assign halt      = timeout_q;

endmodule

// File: tb/tb_sr_trace_buffer.sv
// Self-checking bench: two recorder instances (DEPTH=4 no watchdog, DEPTH=16
// TIMEOUT=20) share stimulus and are compared against a history-based model.
module tb_sr_trace_buffer;

  localparam int DEP[2] = '{4, 16};
  localparam int TOV[2] = '{0, 20};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] val;
    logic [15:0] cyc;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic arm = 1'b0, clear = 1'b0, stopFull = 1'b0, valid = 1'b0;
  logic [31:0] pc = '0, instr = '0, regVal = '0;
  logic [1:0] rdIdxA = '0;
  logic [3:0] rdIdxB = '0;

  logic [31:0] rdPcA, rdInstrA, rdValA, rdPcB, rdInstrB, rdValB;
  logic [15:0] rdCycleA, rdCycleB;
  logic [2:0]  countA;
  logic [4:0]  countB;
  logic wrappedA, capA, toA, haltA, wrappedB, capB, toB, haltB;

  int nChecks = 0;
  int nErrors = 0;

  rec_t hist [2][0:1023];
  int   hLen [2];
  int   mState [2];
  int   mCycle [2];
  bit   mStop [2];
  bit   mTimeout [2];

  always #5 clk = ~clk;

  sr_trace_buffer #(.DEPTH(4), .PC_W(32), .DATA_W(32), .CYCLE_W(16), .TIMEOUT(0)) dutA (
    .clk(clk), .rst(rst), .arm(arm), .clear(clear), .stopFull(stopFull), .valid(valid),
    .pc(pc), .instr(instr), .regVal(regVal), .rdIdx(rdIdxA),
    .rdPc(rdPcA), .rdInstr(rdInstrA), .rdVal(rdValA), .rdCycle(rdCycleA),
    .count(countA), .wrapped(wrappedA), .capturing(capA), .timeout(toA), .halt(haltA)
  );

  sr_trace_buffer #(.DEPTH(16), .PC_W(32), .DATA_W(32), .CYCLE_W(16), .TIMEOUT(20)) dutB (
    .clk(clk), .rst(rst), .arm(arm), .clear(clear), .stopFull(stopFull), .valid(valid),
    .pc(pc), .instr(instr), .regVal(regVal), .rdIdx(rdIdxB),
    .rdPc(rdPcB), .rdInstr(rdInstrB), .rdVal(rdValB), .rdCycle(rdCycleB),
    .count(countB), .wrapped(wrappedB), .capturing(capB), .timeout(toB), .halt(haltB)
  );

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Model: the buffer holds the newest DEPTH records captured since arm.
  function automatic int mCount(input int k);
    return (hLen[k] < DEP[k]) ? hLen[k] : DEP[k];
  endfunction

  function automatic rec_t mEntry(input int k, input int i);
    return hist[k][hLen[k] - mCount(k) + i];
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      hLen[k] = 0; mState[k] = 0; mCycle[k] = 0; mStop[k] = 1'b0; mTimeout[k] = 1'b0;
    end
  endtask

  task automatic modelStep(input int k);
    bit fire;
    rec_t r;
    if (clear) begin
      mState[k] = 0; hLen[k] = 0; mTimeout[k] = 1'b0;
    end else if (mState[k] == 0) begin
      if (arm) begin
        mState[k] = 1; mCycle[k] = 0; hLen[k] = 0; mTimeout[k] = 1'b0; mStop[k] = stopFull;
      end
    end else if (mState[k] == 1) begin
      fire = (TOV[k] != 0) && (mCycle[k] == TOV[k] - 1);
      if (valid) begin
        r.pc = pc; r.instr = instr; r.val = regVal; r.cyc = 16'(mCycle[k]);
        hist[k][hLen[k]] = r;
        hLen[k]++;
      end
      if (mCycle[k] < 65535) mCycle[k]++;
      if (fire) mTimeout[k] = 1'b1;
      if (fire || (mStop[k] && hLen[k] >= DEP[k])) mState[k] = 2;
    end
  endtask

  task automatic checkZero(input string pfx);
    checkOutput({pfx, ".A.count"}, 64'(countA), 64'd0);
    checkOutput({pfx, ".A.flags"}, {wrappedA, capA, toA, haltA}, 64'd0);
    checkOutput({pfx, ".A.rd"}, {rdPcA, rdCycleA}, 64'd0);
    checkOutput({pfx, ".A.rdIV"}, {rdInstrA, rdValA}, 64'd0);
    checkOutput({pfx, ".B.count"}, 64'(countB), 64'd0);
    checkOutput({pfx, ".B.flags"}, {wrappedB, capB, toB, haltB}, 64'd0);
    checkOutput({pfx, ".B.rd"}, {rdPcB, rdCycleB}, 64'd0);
    checkOutput({pfx, ".B.rdIV"}, {rdInstrB, rdValB}, 64'd0);
  endtask

  // One clock: predict reads from pre-edge state, step model, compare after the edge.
  task automatic tick();
    bit   ok [2];
    rec_t e [2];
    int   idx;
    for (int k = 0; k < 2; k++) begin
      idx = (k == 0) ? int'(rdIdxA) : int'(rdIdxB);
      ok[k] = idx < mCount(k);
      e[k]  = ok[k] ? mEntry(k, idx) : '0;
    end
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    checkOutput("A.count", 64'(countA), 64'(mCount(0)));
    checkOutput("A.wrapped", 64'(wrappedA), 64'(hLen[0] > DEP[0]));
    checkOutput("A.capturing", 64'(capA), 64'(mState[0] == 1));
    checkOutput("A.timeout", 64'(toA), 64'(mTimeout[0]));
    checkOutput("A.halt", 64'(haltA), 64'(mTimeout[0]));
    if (ok[0]) begin
      checkOutput("A.rdPc", 64'(rdPcA), 64'(e[0].pc));
      checkOutput("A.rdInstr", 64'(rdInstrA), 64'(e[0].instr));
      checkOutput("A.rdVal", 64'(rdValA), 64'(e[0].val));
      checkOutput("A.rdCycle", 64'(rdCycleA), 64'(e[0].cyc));
    end
    checkOutput("B.count", 64'(countB), 64'(mCount(1)));
    checkOutput("B.wrapped", 64'(wrappedB), 64'(hLen[1] > DEP[1]));
    checkOutput("B.capturing", 64'(capB), 64'(mState[1] == 1));
    checkOutput("B.timeout", 64'(toB), 64'(mTimeout[1]));
    checkOutput("B.halt", 64'(haltB), 64'(mTimeout[1]));
    if (ok[1]) begin
      checkOutput("B.rdPc", 64'(rdPcB), 64'(e[1].pc));
      checkOutput("B.rdInstr", 64'(rdInstrB), 64'(e[1].instr));
      checkOutput("B.rdVal", 64'(rdValB), 64'(e[1].val));
      checkOutput("B.rdCycle", 64'(rdCycleB), 64'(e[1].cyc));
    end
  endtask

  task automatic applyStimulus(input bit a, input bit c, input bit sf, input bit v,
                               input logic [31:0] p, input logic [31:0] ins, input logic [31:0] rv);
    arm = a; clear = c; stopFull = sf; valid = v;
    pc = p; instr = ins; regVal = rv;
    tick();
  endtask

  initial begin
    modelReset();
    #1 rst = 1'b1;
    #2 checkZero("reset");
    #9 rst = 1'b0;

    // Basic capture on the DEPTH=16 instance.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 32'(4 * i), 32'h1000 + 32'(i), 32'h55 + 32'(i));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("basic.count", 64'(countB), 64'd5);
    checkOutput("basic.wrapped", 64'(wrappedB), 64'd0);
    for (int i = 0; i < 5; i++) begin
      rdIdxB = 4'(i);
      tick();
      checkOutput("basic.rdPc", 64'(rdPcB), 64'(4 * i));
      checkOutput("basic.rdCycle", 64'(rdCycleB), 64'(i));
    end

    // Wrap mode on the DEPTH=4 instance.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 32'(i), 32'hA0 + 32'(i), 32'(i * 3));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap.count", 64'(countA), 64'd4);
    checkOutput("wrap.wrapped", 64'(wrappedA), 64'd1);
    rdIdxA = 2'd0;
    tick();
    checkOutput("wrap.rd0", 64'(rdPcA), 64'd2);
    rdIdxA = 2'd3;
    tick();
    checkOutput("wrap.rd3", 64'(rdPcA), 64'd5);

    // Stop-full mode on the DEPTH=4 instance.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 1, 32'(i), 32'hB0 + 32'(i), 32'(i));
      if (i == 3) checkOutput("stop.frozenAt4", 64'(capA), 64'd0);
    end
    valid = 1'b0;
    checkOutput("stop.count", 64'(countA), 64'd4);
    checkOutput("stop.wrapped", 64'(wrappedA), 64'd0);
    for (int i = 0; i < 4; i++) begin
      rdIdxA = 2'(i);
      tick();
      checkOutput("stop.rdPc", 64'(rdPcA), 64'(i));
    end

    // Watchdog on the TIMEOUT=20 instance.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 1, 32'h200 + 32'(i), 32'(i), 32'(i));
      if (i == 18) checkOutput("wd.notYet", 64'(toB), 64'd0);
    end
    checkOutput("wd.timeout", 64'(toB), 64'd1);
    checkOutput("wd.halt", 64'(haltB), 64'd1);
    checkOutput("wd.count", 64'(countB), 64'd16);
    checkOutput("wd.wrapped", 64'(wrappedB), 64'd1);
    checkOutput("wd.frozen", 64'(capB), 64'd0);
    valid = 1'b0;
    rdIdxB = 4'd15;
    tick();
    checkOutput("wd.newestStamp", 64'(rdCycleB), 64'd19);

    // Clear beats arm and valid.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h300, 0, 0);
    applyStimulus(1, 1, 0, 1, 32'h304, 0, 0);
    checkOutput("clear.capturing", 64'(capB), 64'd0);
    checkOutput("clear.count", 64'(countB), 64'd0);
    checkOutput("clear.countA", 64'(countA), 64'd0);

    // Asynchronous reset in the middle of a capture.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    rdIdxA = 2'd0;
    rdIdxB = 4'd0;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 32'h400 + 32'(i), 32'h7 + 32'(i), 32'h9);
    #1 rst = 1'b1;
    #1 checkZero("midReset");
    modelReset();
    #1 rst = 1'b0;
    arm = 1'b0; valid = 1'b0;
    tick();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      rdIdxA = 2'($urandom);
      rdIdxB = 4'($urandom);
      applyStimulus(($urandom % 6) == 0,
                    ($urandom_range(0, 39) == 0) || (hLen[0] > 900),
                    1'($urandom),
                    ($urandom % 3) != 0,
                    $urandom, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
